// File: rtl/hazard_unit_if.sv
// hazard_unit_if -- decode-side bundle between the decode stage and hazard_unit.
//
// Signals (driven by the decode stage / master):
//   validD            D stage holds a real instruction
//   rs0, rs1 [5:0]    D-stage sources, bit 5 selects the FP register file
//   use0, use1        D-stage instruction actually reads rs0 / rs1
//   rd [5:0]          D-stage destination
//   regwrite          D-stage instruction writes rd
//   memread           D-stage instruction is a load
//   fpumulti          D-stage instruction is a multi-cycle FPU op
//   branchjump, flag  branch/jump in D and its resolved condition
// Signals (driven by hazard_unit / slave):
//   forward0, forward1 [1:0]  operand selects (00 regfile, 01 E, 10 M)
//   stallF, stallD, stallE    hold PC, F/D, D/E
//   flushD, flushE, flushM    bubble into F/D, D/E, E/M
interface hazard_unit_if;
  logic       validD;
  logic [5:0] rs0;
  logic [5:0] rs1;
  logic       use0;
  logic       use1;
  logic [5:0] rd;
  logic       regwrite;
  logic       memread;
  logic       fpumulti;
  logic       branchjump;
  logic       flag;
  logic [1:0] forward0;
  logic [1:0] forward1;
  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       flushD;
  logic       flushE;
  logic       flushM;

  modport master (
    output validD, rs0, rs1, use0, use1, rd, regwrite, memread, fpumulti, branchjump, flag,
    input  forward0, forward1, stallF, stallD, stallE, flushD, flushE, flushM
  );

  modport slave (
    input  validD, rs0, rs1, use0, use1, rd, regwrite, memread, fpumulti, branchjump, flag,
    output forward0, forward1, stallF, stallD, stallE, flushD, flushE, flushM
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit -- hazard controller for the 5-stage core.
//
// Keeps shadow records {valid, rd, regwrite, memread} of the E and M stage
// instructions and derives, combinationally from them and the D-stage fields:
// operand forwarding selects, load-use stall, multi-cycle FPU interlock and
// taken-branch redirect flush.
//
// Ports:
//   FPU_LAT   parameter, E-stage occupancy of a multi-cycle FPU op (>= 2)
//   clk       rising-edge clock
//   rstn      asynchronous active-low reset
//   hz        hazard_unit_if.slave, D-stage fields in, forward/stall/flush out
//
// Build option: define HAZARD_FPU_INTERLOCK_EN to build the FPU busy counter
// and drive stallE/flushM. Left undefined, fpumulti is ignored and
// stallE/flushM are constant 0.
module hazard_unit #(
  parameter int FPU_LAT = 4
) (
  input  logic         clk,
  input  logic         rstn,
  hazard_unit_if.slave hz
);

  localparam logic [3:0] FPU_LAT_M1 = 4'(FPU_LAT - 1);

  logic       e_valid_q, e_valid_d;
  logic [5:0] e_rd_q, e_rd_d;
  logic       e_wr_q, e_wr_d;
  logic       e_ld_q, e_ld_d;
  logic       m_valid_q, m_valid_d;
  logic [5:0] m_rd_q, m_rd_d;
  logic       m_wr_q, m_wr_d;
  logic       out_en_q;

  logic       e_elig_s;
  logic       m_elig_s;
  logic       fpu_busy_s;
  logic       load_use_s;
  logic       stall_fd_s;
  logic       redirect_s;
  logic       stall_e_s;
  logic       flush_e_s;

  // Forward select for one source operand; E wins over M, loads in E never forward.
  function automatic logic [1:0] fwd_sel(
    input logic       use_i,
    input logic [5:0] rs_i,
    input logic       e_elig_i,
    input logic [5:0] e_rd_i,
    input logic       e_ld_i,
    input logic       m_elig_i,
    input logic [5:0] m_rd_i
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (!use_i) begin
      sel = 2'b00;
    end else if (e_elig_i && !e_ld_i && (e_rd_i == rs_i)) begin
      sel = 2'b01;
    end else if (m_elig_i && (m_rd_i == rs_i)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // x0 is hard-wired zero; f0 (6'd32) is an ordinary register.
  assign e_elig_s = e_valid_q && e_wr_q && (e_rd_q != 6'd0);
  assign m_elig_s = m_valid_q && m_wr_q && (m_rd_q != 6'd0);

  // Load-use only matters when the FPU is not already holding the pipe.
  assign load_use_s = hz.validD && e_elig_s && e_ld_q && !fpu_busy_s &&
                      ((hz.use0 && (e_rd_q == hz.rs0)) || (hz.use1 && (e_rd_q == hz.rs1)));
  assign stall_fd_s = fpu_busy_s || load_use_s;
  // A redirect under a stall is dropped; decode re-presents the branch later.
  assign redirect_s = hz.validD && hz.branchjump && hz.flag && !stall_fd_s;

  // Controls as seen by the pipeline; all quiet in the first cycle after reset.
  assign stall_e_s = out_en_q && fpu_busy_s;
  assign flush_e_s = out_en_q && load_use_s;

`ifdef HAZARD_FPU_INTERLOCK_EN
  logic [3:0] cnt_q, cnt_d;

  // Busy counter: reload when a multi-cycle op enters E, count down while holding it.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else if (!flush_e_s && hz.validD && hz.fpumulti) begin
      cnt_d = FPU_LAT_M1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Busy counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fpu_busy_s = (cnt_q != 4'd0);
`else
  logic unused_fpu_s;
  assign unused_fpu_s = ^{hz.fpumulti, FPU_LAT_M1};
  assign fpu_busy_s   = 1'b0;
`endif

  // Shadow record next state: hold E and bubble M on FPU stall, bubble E on load-use.
  always_comb begin
    e_valid_d = e_valid_q;
    e_rd_d    = e_rd_q;
    e_wr_d    = e_wr_q;
    e_ld_d    = e_ld_q;
    m_valid_d = m_valid_q;
    m_rd_d    = m_rd_q;
    m_wr_d    = m_wr_q;
    if (stall_e_s) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = e_valid_q;
      m_rd_d    = e_rd_q;
      m_wr_d    = e_wr_q;
      if (flush_e_s) begin
        e_valid_d = 1'b0;
      end else begin
        e_valid_d = hz.validD;
        e_rd_d    = hz.rd;
        e_wr_d    = hz.regwrite;
        e_ld_d    = hz.memread;
      end
    end
  end

  // Shadow record registers and the post-reset output enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      e_valid_q <= 1'b0;
      e_rd_q    <= 6'd0;
      e_wr_q    <= 1'b0;
      e_ld_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_rd_q    <= 6'd0;
      m_wr_q    <= 1'b0;
      out_en_q  <= 1'b0;
    end else begin
      e_valid_q <= e_valid_d;
      e_rd_q    <= e_rd_d;
      e_wr_q    <= e_wr_d;
      e_ld_q    <= e_ld_d;
      m_valid_q <= m_valid_d;
      m_rd_q    <= m_rd_d;
      m_wr_q    <= m_wr_d;
      out_en_q  <= 1'b1;
    end
  end

  // Output drive; forced to 0 until the first edge after reset release.
  always_comb begin
    hz.forward0 = 2'b00;
    hz.forward1 = 2'b00;
    hz.stallF   = 1'b0;
    hz.stallD   = 1'b0;
    hz.stallE   = 1'b0;
    hz.flushD   = 1'b0;
    hz.flushE   = 1'b0;
    hz.flushM   = 1'b0;
    if (out_en_q) begin
      hz.forward0 = fwd_sel(hz.use0, hz.rs0, e_elig_s, e_rd_q, e_ld_q, m_elig_s, m_rd_q);
      hz.forward1 = fwd_sel(hz.use1, hz.rs1, e_elig_s, e_rd_q, e_ld_q, m_elig_s, m_rd_q);
      hz.stallF   = stall_fd_s;
      hz.stallD   = stall_fd_s;
      hz.stallE   = fpu_busy_s;
      hz.flushD   = redirect_s;
      hz.flushE   = load_use_s;
      hz.flushM   = fpu_busy_s;
    end else begin
      hz.forward0 = 2'b00;
      hz.forward1 = 2'b00;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit -- directed and random stimulus for hazard_unit, checked
// against an instruction-level model of the E/M stages kept in the bench.
module tb_hazard_unit;
  localparam int FPU_LAT = 4;
`ifdef HAZARD_FPU_INTERLOCK_EN
  localparam bit FPU_EN = 1'b1;
`else
  localparam bit FPU_EN = 1'b0;
`endif

  logic clk;
  logic rstn;
  hazard_unit_if hz();

  hazard_unit #(.FPU_LAT(FPU_LAT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .hz   (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit valid;
    int rd;
    bit wr;
    bit ld;
  } ins_t;

  ins_t me;
  ins_t mm;
  int   fpu_left;
  bit   live;

  logic [1:0] x_f0, x_f1;
  logic       x_sf, x_sd, x_se, x_fd, x_fe, x_fm;

  function automatic bit writes(input ins_t x);
    return x.valid && x.wr && (x.rd != 0);
  endfunction

  function automatic logic [1:0] fwd(input bit u, input int rs);
    if (!u) return 2'b00;
    if (writes(me) && !me.ld && me.rd == rs) return 2'b01;
    if (writes(mm) && mm.rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_eval();
    bit busy;
    bit hit;
    bit lu;
    busy = FPU_EN && (fpu_left > 0);
    hit  = (hz.use0 && me.rd == int'(hz.rs0)) || (hz.use1 && me.rd == int'(hz.rs1));
    lu   = !busy && hz.validD && writes(me) && me.ld && hit;
    x_f0 = 2'b00; x_f1 = 2'b00;
    x_sf = 1'b0; x_sd = 1'b0; x_se = 1'b0; x_fd = 1'b0; x_fe = 1'b0; x_fm = 1'b0;
    if (rstn && live) begin
      x_f0 = fwd(hz.use0, int'(hz.rs0));
      x_f1 = fwd(hz.use1, int'(hz.rs1));
      x_sf = busy || lu;
      x_sd = busy || lu;
      x_se = busy;
      x_fm = busy;
      x_fe = lu;
      x_fd = hz.validD && hz.branchjump && hz.flag && !busy && !lu;
    end
  endfunction

  task automatic model_reset();
    me = '{valid: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
    mm = '{valid: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
    fpu_left = 0;
    live = 1'b0;
  endtask

  task automatic model_step();
    if (!rstn) begin
      model_reset();
    end else begin
      model_eval();
      if (FPU_EN && fpu_left > 0) begin
        fpu_left = fpu_left - 1;
        mm.valid = 1'b0;
      end else begin
        mm = me;
        if (x_fe) begin
          me.valid = 1'b0;
        end else begin
          me = '{valid: hz.validD, rd: int'(hz.rd), wr: hz.regwrite, ld: hz.memread};
          if (FPU_EN && hz.validD && hz.fpumulti) fpu_left = FPU_LAT - 1;
        end
      end
      live = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    model_eval();
    chk("forward0", hz.forward0, x_f0);
    chk("forward1", hz.forward1, x_f1);
    chk("stallF", {1'b0, hz.stallF}, {1'b0, x_sf});
    chk("stallD", {1'b0, hz.stallD}, {1'b0, x_sd});
    chk("stallE", {1'b0, hz.stallE}, {1'b0, x_se});
    chk("flushD", {1'b0, hz.flushD}, {1'b0, x_fd});
    chk("flushE", {1'b0, hz.flushE}, {1'b0, x_fe});
    chk("flushM", {1'b0, hz.flushM}, {1'b0, x_fm});
  endtask

  task automatic chk_all_zero(input string tag);
    logic [11:0] outs;
    outs = {hz.forward0, hz.forward1, hz.stallF, hz.stallD, hz.stallE,
            hz.flushD, hz.flushE, hz.flushM, 2'b00};
    total++;
    assert (outs === 12'd0) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=0", tag, outs);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic setd(input bit v, input logic [5:0] r0, input bit u0,
                      input logic [5:0] r1, input bit u1, input logic [5:0] d,
                      input bit w, input bit ld, input bit fp, input bit bj, input bit fl);
    hz.validD = v;  hz.rs0 = r0; hz.use0 = u0; hz.rs1 = r1; hz.use1 = u1;
    hz.rd = d; hz.regwrite = w; hz.memread = ld; hz.fpumulti = fp;
    hz.branchjump = bj; hz.flag = fl;
  endtask

  initial begin
    int n_se;
    int n_fm;
    logic [5:0] pool [6];
    pool[0] = 6'd0; pool[1] = 6'd1; pool[2] = 6'd2;
    pool[3] = 6'd3; pool[4] = 6'd32; pool[5] = 6'd33;

    model_reset();
    rstn = 1'b0;
    setd(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_outputs");

    // release reset with a taken branch waiting in D: still quiet this cycle
    rstn = 1'b1;
    setd(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1; chk("first_cycle_flushD", {1'b0, hz.flushD}, 2'b00);
    tick();
    #1; chk("branch_flushD", {1'b0, hz.flushD}, 2'b01);
    tick();

    // forwarding from E, and x0 never forwarded
    setd(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    setd(1'b1, 6'd5, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; chk("fwd_from_E", hz.forward0, 2'b01);
    tick();
    setd(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    setd(1'b1, 6'd0, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; chk("fwd_x0", hz.forward0, 2'b00);
    tick();

    // E over M priority on f5 (6'd37)
    setd(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd37, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    setd(1'b1, 6'd0, 1'b0, 6'd37, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; chk("fwd_E_over_M", hz.forward1, 2'b01);
    tick();
    setd(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd37, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    setd(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd37, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    setd(1'b1, 6'd0, 1'b0, 6'd37, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; chk("fwd_M_E_invalid", hz.forward1, 2'b10);
    tick();

    // load-use: one-cycle stall with E bubble, then forward from M
    setd(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    setd(1'b1, 6'd3, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu_stallF", {1'b0, hz.stallF}, 2'b01);
    chk("lu_stallD", {1'b0, hz.stallD}, 2'b01);
    chk("lu_flushE", {1'b0, hz.flushE}, 2'b01);
    tick();
    #1;
    chk("lu_release", {1'b0, hz.stallF}, 2'b00);
    chk("lu_fwd_M", hz.forward0, 2'b10);
    tick();
    setd(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    setd(1'b1, 6'd3, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; chk("lu_unused_src", {1'b0, hz.stallD}, 2'b00);
    tick();

    // taken branch behind a load-use stall is deferred one cycle
    setd(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    setd(1'b1, 6'd4, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1; chk("br_under_stall", {1'b0, hz.flushD}, 2'b00);
    tick();
    #1; chk("br_after_stall", {1'b0, hz.flushD}, 2'b01);
    tick();

    // FPU interlock length
    setd(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    setd(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_se = 0;
    n_fm = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_se += int'(hz.stallE);
      n_fm += int'(hz.flushM);
      tick();
    end
    chk("fpu_stallE_cycles", 2'(n_se), FPU_EN ? 2'(FPU_LAT - 1) : 2'd0);
    chk("fpu_flushM_cycles", 2'(n_fm), FPU_EN ? 2'(FPU_LAT - 1) : 2'd0);

    // asynchronous reset in the middle of an FPU stall
    setd(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    setd(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    setd(1'b1, 6'd33, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    rstn = 1'b0;
    #1; chk_all_zero("async_reset_now");
    tick();
    rstn = 1'b1;
    setd(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    setd(1'b1, 6'd33, 1'b1, 6'd33, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; chk("no_stale_fwd", hz.forward0, 2'b00);
    tick();

    // random traffic over a small register pool, occasional reset
    for (int i = 0; i < 500; i++) begin
      rstn = ($urandom_range(0, 59) != 0);
      setd($urandom_range(0, 7) != 0,
           pool[$urandom_range(0, 5)], $urandom_range(0, 1) == 1,
           pool[$urandom_range(0, 5)], $urandom_range(0, 1) == 1,
           pool[$urandom_range(0, 5)], $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage core. It produces the `forward0`/`forward1` selects and the stall/flush controls that the decode stage and the pipeline registers consume. It keeps its own shadow records of the instructions in the E and M stages, so it needs no pipeline-register taps. It also detects load-use hazards, holds the pipeline for multi-cycle FPU operations, and kills the wrong-path instruction on a taken branch or jump.

## Interface
- `FPU_LAT`, default 4: E-stage occupancy in cycles of a multi-cycle FPU op (fdiv/fsqrt); must be ≥ 2.
- `clk` in 1: system clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `validD` in 1: D stage holds a real instruction.
- `rs0`, `rs1` in 6: D-stage source registers; bit 5 set means FP register file.
- `use0`, `use1` in 1: D-stage instruction actually reads `rs0` / `rs1`.
- `rd` in 6: D-stage destination register.
- `regwrite` in 1: D-stage instruction writes `rd`.
- `memread` in 1: D-stage instruction is a load.
- `fpumulti` in 1: D-stage instruction is a multi-cycle FPU op.
- `branchjump` in 1: D-stage instruction is a branch or jump.
- `flag` in 1: branch condition from decode; jumps drive 1.
- `forward0`, `forward1` out 2: 00 = regfile, 01 = E result (`regwdataE`), 10 = M result (`regwdataM`); 11 is never driven.
- `stallF`, `stallD`, `stallE` out 1: hold the PC, the F/D register, and the D/E register respectively.
- `flushD` out 1: the F/D register loads a bubble.
- `flushE` out 1: the D/E register loads a bubble.
- `flushM` out 1: the E/M register loads a bubble.

## Operation
- **Shadow records.** E and M records each hold {valid, rd, regwrite, memread}.
  - Normal edge: E ← D fields (valid = `validD`), and M ← E.
  - `flushE`: E record ← invalid.
  - `stallE`: E record holds, and M ← invalid.
- **Hazard-eligible register.** A destination register is eligible only when regwrite=1 and rd ≠ 6'd0. Integer x0 is never forwarded; 6'd32 (f0) is an ordinary register.
- **Forwarding (combinational).** For each source `rsN`:
  - If E.valid, E is eligible, E.rd == `rsN`, and E is not a load → 01.
  - Else if M.valid, M is eligible, and M.rd == `rsN` → 10 (this covers loads).
  - Else → 00.
  - E has priority over M. `useN`=0 forces 00.
- **Load-use hazard.** Triggered when E.valid & E.memread & E is eligible & (`use0` & E.rd==`rs0` | `use1` & E.rd==`rs1`) & `validD`.
  - Response: `stallF`=`stallD`=1 and `flushE`=1 for exactly one cycle. The next cycle forwards 10.
- **FPU interlock.** 4-bit busy counter `cnt`.
  - Loads `FPU_LAT-1` when a non-stalled, valid `fpumulti` instruction enters E.
  - While `cnt` ≠ 0: `stallF`=`stallD`=`stallE`=1, `flushM`=1, and `cnt` decrements.
- **Redirect.** Triggered when `validD` & `branchjump` & `flag` and no stall is asserted this cycle.
  - Response: `flushD`=1, killing the instruction fetched behind the branch.
- **Priority.** FPU busy > load-use > redirect. A redirect that coincides with a stall is suppressed; decode re-evaluates it once the stall releases.
- **Combined D-stage decision.** `flushE` = load-use only. FPU busy holds E; it does not flush it.

## Timing
- Forward selects, stalls and flushes are combinational from the current inputs and the current records, within the same cycle as decode.
- Records and `cnt` update on the rising edge of `clk`.
- Load-use stall lasts 1 cycle. FPU op stall lasts `FPU_LAT-1` cycles after entry.
- Taken branch costs 1 bubble.
- Reset (`rstn`=0, asynchronous):
  - Records invalid and `cnt`=0.
  - All outputs 0, including `forward0` = `forward1` = 00.
  - Outputs stay 0 until the first edge after deassertion.
  - Reset mid-stall aborts the stall immediately.

## Configuration
- `HAZARD_FPU_INTERLOCK_EN`:
  - Defined: the FPU busy counter and `stallE`/`flushM` are generated as described above.
  - Undefined: `fpumulti` is ignored, no counter is built, and `stallE` and `flushM` are tied to 0. This is for builds where every FPU op is single-cycle.

## Test plan
- **Forwarding from E.** E = add rd=5, D reads rs0=5 → `forward0`=01. Same with rd=0 → 00.
- **E vs M priority.** E and M both write 6'd37, D reads rs1=37 → `forward1`=01. With E invalid → 10.
- **Load-use.** E = load rd=3, D uses rs0=3.
  - Cycle 0: `stallF`=`stallD`=`flushE`=1.
  - Cycle 1: stalls 0, `forward0`=10.
  - With `use0`=0 → no stall.
- **FPU interlock.** fdiv enters E with `FPU_LAT`=4 → `stallE`=`flushM`=1 for 3 cycles, then release. With the macro undefined → no stall.
- **Taken branch.** `branchjump`=1, `flag`=1 → `flushD`=1 for 1 cycle. Same during a load-use stall → `flushD`=0 that cycle, 1 on the next cycle.
- **Async reset.** Assert `rstn`=0 mid FPU stall → all outputs 0 without waiting for a clock edge. After release, a following instruction sees no stale forwarding.
